// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: turns the UART receiver byte stream into command frames
// (opcode, address bytes MSB first, write-data bytes MSB first for writes) and
// presents each frame on a valid/ready command port. Frames are abandoned on an
// inter-byte timeout, on a BREAK, or when enable drops mid-frame.
module uart_cmd_sequencer #(
  parameter int          ADDR_BYTES     = 4,
  parameter int          DATA_BYTES     = 4,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  OP_WRITE       = 8'h57,
  parameter logic [7:0]  OP_READ        = 8'h52
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  output logic                    uart_rx_en,
  input  logic                    rx_valid,
  input  logic                    rx_break,
  input  logic [7:0]              rx_data,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic                    cmd_write,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    err_opcode,
  output logic                    err_timeout,
  output logic                    err_overrun,
  input  logic                    clr_err,
  output logic                    busy
);

  localparam int AW = 8*ADDR_BYTES;
  localparam int DW = 8*DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADDR  = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] ISSUE = 2'd3;

  logic [1:0]    state;
  logic [2:0]    byte_cnt;
  logic [TW-1:0] to_cnt;
  logic          rx_byte;
  logic          abort;
  logic          ovr_set;

  // Receiver enable and status outputs are straight decodes of inputs/state.
  always_comb begin
    uart_rx_en = enable;
    cmd_valid  = (state == ISSUE);
    busy       = (state != IDLE);
    rx_byte    = rx_valid && !rx_break;
    // Mid-frame abort: enable dropped or BREAK seen; neither raises an error.
    abort      = !enable || (rx_valid && rx_break);
    // Anything arriving while a command waits is lost.
    ovr_set    = (state == ISSUE) && rx_valid;
  end

  // Frame FSM, byte/timeout counters, command registers and error flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      cmd_write   <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
      if (ovr_set)      err_overrun <= 1'b1;
      else if (clr_err) err_overrun <= 1'b0;

      case (state)
        IDLE: begin
          byte_cnt <= '0;
          to_cnt   <= '0;
          if (enable && rx_byte) begin
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              cmd_write <= (rx_data == OP_WRITE);
              cmd_addr  <= '0;
              cmd_wdata <= '0;
              state     <= ADDR;
            end else begin
              err_opcode <= 1'b1;
            end
          end
        end

        ADDR: begin
          if (abort) begin
            state <= IDLE;
          end else if (rx_valid) begin
            // Shift left one byte; the sized cast drops the old top byte.
            cmd_addr <= AW'({cmd_addr, rx_data});
            to_cnt   <= '0;
            if (byte_cnt == ADDR_LAST) begin
              byte_cnt <= '0;
              state    <= cmd_write ? DATA : ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (to_cnt == TO_LAST) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        DATA: begin
          if (abort) begin
            state <= IDLE;
          end else if (rx_valid) begin
            cmd_wdata <= DW'({cmd_wdata, rx_data});
            to_cnt    <= '0;
            if (byte_cnt == DATA_LAST) begin
              byte_cnt <= '0;
              state    <= ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (to_cnt == TO_LAST) begin
            state       <= IDLE;
            err_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end

        default: begin // ISSUE: hold the command until the consumer takes it
          byte_cnt <= '0;
          to_cnt   <= '0;
          if (cmd_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: directed frames from the test plan plus random
// byte streams, all checked every cycle against a frame-level model that keeps
// the received bytes in a queue and rebuilds the command from them.
module tb_uart_cmd_sequencer;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        resetn, enable, rx_valid, rx_break, cmd_ready, clr_err;
  logic [7:0]  rx_data;
  logic        uart_rx_en, cmd_valid, cmd_write, err_opcode, err_timeout, err_overrun, busy;
  logic [31:0] cmd_addr, cmd_wdata;

  int cnt_vec = 0;
  int cnt_err = 0;

  uart_cmd_sequencer #(.ADDR_BYTES(4), .DATA_BYTES(4), .TIMEOUT_CYCLES(TO),
                       .OP_WRITE(8'h57), .OP_READ(8'h52)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .uart_rx_en(uart_rx_en),
    .rx_valid(rx_valid), .rx_break(rx_break), .rx_data(rx_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .err_opcode(err_opcode),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .clr_err(clr_err),
    .busy(busy));

  always #5 clk = ~clk;

  // ---- model state ----
  bit          m_coll, m_iss, m_write, m_eop, m_eto, m_ovr, m_rst;
  int          m_gap;
  logic [31:0] m_addr, m_wdata;
  logic [7:0]  q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cnt_vec++;
    if (act !== exp) begin
      cnt_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the frame-level model, using the inputs present at the edge.
  task automatic model_step();
    bit ovr_set;
    m_eop = 0; m_eto = 0; m_rst = 0;
    if (!resetn) begin
      m_coll = 0; m_iss = 0; m_write = 0; m_ovr = 0; m_gap = 0;
      m_addr = 0; m_wdata = 0; q.delete(); m_rst = 1;
      return;
    end
    ovr_set = m_iss && rx_valid;
    if (m_iss) begin
      if (cmd_ready) m_iss = 0;
    end else if (m_coll) begin
      if (!enable || (rx_valid && rx_break)) m_coll = 0;
      else if (rx_valid) begin
        q.push_back(rx_data);
        m_gap = 0;
        if (q.size() == (m_write ? 9 : 5)) begin
          m_addr = 0; m_wdata = 0;
          for (int i = 1; i <= 4; i++) m_addr = (m_addr << 8) | 32'(q[i]);
          if (m_write) for (int i = 5; i <= 8; i++) m_wdata = (m_wdata << 8) | 32'(q[i]);
          m_coll = 0; m_iss = 1;
        end
      end else if (m_gap == TO - 1) begin
        m_coll = 0; m_eto = 1;
      end else m_gap++;
    end else if (enable && rx_valid && !rx_break) begin
      if (rx_data == 8'h57 || rx_data == 8'h52) begin
        m_coll = 1; m_write = (rx_data == 8'h57); m_gap = 0;
        q.delete(); q.push_back(rx_data);
      end else m_eop = 1;
    end
    m_ovr = ovr_set || (m_ovr && !clr_err);
  endtask

  // Advance one clock: model at the edge, compare on the following negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cmd_valid", cmd_valid, m_iss);
    chk("busy", busy, m_coll || m_iss);
    chk("err_opcode", err_opcode, m_eop);
    chk("err_timeout", err_timeout, m_eto);
    chk("err_overrun", err_overrun, m_ovr);
    chk("uart_rx_en", uart_rx_en, enable);
    if (m_iss || m_rst) begin
      chk("cmd_write", cmd_write, m_iss ? m_write : 1'b0);
      chk("cmd_addr", cmd_addr, m_iss ? m_addr : 32'h0);
      chk("cmd_wdata", cmd_wdata, m_iss ? m_wdata : 32'h0);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic brk);
    rx_valid = 1; rx_data = b; rx_break = brk;
    cycle();
    rx_valid = 0; rx_break = 0; rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [7:0] wr[9];
    logic [7:0] rd[5];
    int k;
    wr = '{8'h57, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rd = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00};

    resetn = 0; enable = 1; rx_valid = 0; rx_break = 0; rx_data = 0;
    cmd_ready = 0; clr_err = 0;
    @(negedge clk);
    idle(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", cmd_addr, 32'h0);
    resetn = 1;
    idle(2);

    // Write frame, consumer always ready.
    cmd_ready = 1;
    foreach (wr[i]) send(wr[i], 0);
    chk("wr_valid", cmd_valid, 1'b1);
    chk("wr_write", cmd_write, 1'b1);
    chk("wr_addr", cmd_addr, 32'h12345678);
    chk("wr_wdata", cmd_wdata, 32'hDEADBEEF);
    chk("model_wr_addr", m_addr, 32'h12345678);
    cycle();
    chk("wr_done_valid", cmd_valid, 1'b0);
    chk("wr_done_busy", busy, 1'b0);

    // Read with 20 cycles of backpressure; enable dropped while holding.
    cmd_ready = 0;
    foreach (rd[i]) send(rd[i], 0);
    enable = 0;
    idle(20);
    enable = 1;
    chk("rd_held_valid", cmd_valid, 1'b1);
    chk("rd_write", cmd_write, 1'b0);
    chk("rd_addr", cmd_addr, 32'h00000100);
    chk("rd_wdata", cmd_wdata, 32'h0);
    chk("model_rd_addr", m_addr, 32'h00000100);
    cmd_ready = 1;
    cycle();
    chk("rd_done_valid", cmd_valid, 1'b0);

    // Unknown opcode, then a good frame.
    send(8'h41, 0);
    chk("op_pulse", err_opcode, 1'b1);
    chk("op_no_busy", busy, 1'b0);
    cycle();
    chk("op_pulse_end", err_opcode, 1'b0);
    foreach (wr[i]) send(wr[i], 0);
    chk("op_next_addr", cmd_addr, 32'h12345678);
    cycle();

    // Timeout exactly TO edges after the last accepted byte.
    send(8'h57, 0); send(8'h12, 0);
    k = 0;
    while (!err_timeout && k < 3*TO) begin cycle(); k++; end
    chk("to_latency", 32'(k), 32'(TO));
    chk("to_idle", busy, 1'b0);
    cycle();
    chk("to_pulse_end", err_timeout, 1'b0);

    // A byte 99 edges after, then one on the terminal edge, both continue.
    send(8'h52, 0); send(8'h12, 0);
    idle(TO - 2); send(8'h34, 0);
    chk("to99_busy", busy, 1'b1);
    idle(TO - 1); send(8'h56, 0);
    chk("to100_busy", busy, 1'b1);
    send(8'h78, 0);
    chk("to_frame_addr", cmd_addr, 32'h12345678);
    chk("to_frame_valid", cmd_valid, 1'b1);
    cycle();

    // Break abort, then a read frame.
    send(8'h57, 0); send(8'h12, 0); send(8'h34, 0); send(8'h00, 1);
    chk("brk_idle", busy, 1'b0);
    chk("brk_noerr", err_timeout | err_opcode, 1'b0);
    send(8'h52, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    chk("brk_next_addr", cmd_addr, 32'hAABBCCDD);
    cycle();

    // Overrun: sticky, clr clears, set beats clr, accept-cycle byte also counts.
    cmd_ready = 0;
    send(8'h52, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h99, 0);
    chk("ovr_set", err_overrun, 1'b1);
    chk("ovr_addr_held", cmd_addr, 32'h01020304);
    clr_err = 1; cycle(); clr_err = 0;
    chk("ovr_clr", err_overrun, 1'b0);
    clr_err = 1; send(8'h55, 1); clr_err = 0;
    chk("ovr_set_wins", err_overrun, 1'b1);
    clr_err = 1; cycle(); clr_err = 0;
    cmd_ready = 1; send(8'h57, 0);
    chk("ovr_accept_cycle", err_overrun, 1'b1);
    chk("ovr_accept_idle", busy, 1'b0);
    clr_err = 1; cycle(); clr_err = 0;

    // Reset mid-ADDR.
    send(8'h57, 0); send(8'h12, 0);
    resetn = 0; cycle(); resetn = 1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_addr", cmd_addr, 32'h0);
    chk("rst_mid_write", cmd_write, 1'b0);

    // Random dense traffic.
    for (int i = 0; i < 3000; i++) begin
      rx_valid  = ($urandom_range(0, 2) == 0);
      rx_break  = ($urandom_range(0, 19) == 0);
      rx_data   = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52)
                                              : 8'($urandom);
      cmd_ready = ($urandom_range(0, 2) == 0);
      enable    = ($urandom_range(0, 49) != 0);
      clr_err   = ($urandom_range(0, 29) == 0);
      resetn    = ($urandom_range(0, 499) != 0);
      cycle();
    end
    // Random sparse traffic so inter-byte gaps straddle the timeout.
    resetn = 1; enable = 1; rx_break = 0; clr_err = 0;
    for (int i = 0; i < 4000; i++) begin
      rx_valid  = ($urandom_range(0, 109) == 0);
      rx_data   = ($urandom_range(0, 1) == 0) ? 8'h52 : 8'($urandom);
      cmd_ready = ($urandom_range(0, 3) == 0);
      clr_err   = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", cnt_vec, cnt_err);
    $finish;
  end

endmodule
